// File: rtl/wb_trace_buffer_if.sv
// Trace record port: the buffer sources records (master), a checker or trace sink drains them (slave).
interface wb_trace_buffer_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned SEQ_WIDTH      = 16
);
    logic                      trace_valid;
    logic                      trace_ready;
    logic [REG_ADDR_WIDTH-1:0] trace_rd;
    logic [DATA_WIDTH-1:0]     trace_data;
    logic [SEQ_WIDTH-1:0]      trace_seq;

    modport master (
        output trace_valid,
        output trace_rd,
        output trace_data,
        output trace_seq,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_rd,
        input  trace_data,
        input  trace_seq,
        output trace_ready
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback retirement trace: shadow register file plus a sequence-numbered record FIFO.
// Never stalls the pipeline; records that do not fit are counted as drops.
module wb_trace_buffer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned SEQ_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic                      clear_i,
    wb_trace_buffer_if.master         trace_if,
    input  logic [REG_ADDR_WIDTH-1:0] shadow_addr_i,
    output logic [DATA_WIDTH-1:0]     shadow_data_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [SEQ_WIDTH-1:0]      dropped_o
);
    localparam int unsigned PtrW      = $clog2(DEPTH);
    localparam int unsigned NumRegs   = 2 ** REG_ADDR_WIDTH;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [REG_ADDR_WIDTH-1:0] r_mem_rd   [DEPTH];
    logic [DATA_WIDTH-1:0]     r_mem_data [DEPTH];
    logic [SEQ_WIDTH-1:0]      r_mem_seq  [DEPTH];
    logic [DATA_WIDTH-1:0]     r_shadow   [NumRegs];

    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [PtrW:0]        r_count;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic                 r_overflow;
    logic [SEQ_WIDTH-1:0] r_dropped;

    logic w_event;
    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    always_comb begin
        w_event = wb_we_i && (wb_rd_i != '0);
        w_valid = (r_count != '0);
        w_full  = (r_count == FullCount);
        w_pop   = w_valid && trace_if.trace_ready && !clear_i;
        // A full FIFO still accepts the push when the head leaves in the same cycle.
        w_push  = w_event && !clear_i && (!w_full || w_pop);
        w_drop  = w_event && !clear_i && !w_push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (clear_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + (PtrW + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PtrW + 1)'(1);
            end
            // Drops still consume a sequence number so the sink can see the gap.
            if (w_event) r_seq <= r_seq + SEQ_WIDTH'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != '1) r_dropped <= r_dropped + SEQ_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= wb_rd_i;
            r_mem_data[r_wptr] <= wb_data_i;
            r_mem_seq[r_wptr]  <= r_seq;
        end
    end

    // Shadow file tracks every event, including dropped ones and those in a clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) r_shadow[i] <= '0;
        end else if (w_event) begin
            r_shadow[wb_rd_i] <= wb_data_i;
        end
    end

    assign shadow_data_o = (shadow_addr_i == '0) ? '0 : r_shadow[shadow_addr_i];

    assign trace_if.trace_valid = w_valid;
    assign trace_if.trace_rd    = w_valid ? r_mem_rd[r_rptr]   : '0;
    assign trace_if.trace_data  = w_valid ? r_mem_data[r_rptr] : '0;
    assign trace_if.trace_seq   = w_valid ? r_mem_seq[r_rptr]  : '0;

    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign dropped_o  = r_dropped;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_trace_buffer;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SW    = 16;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [SW-1:0] seq;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_we_i;
    logic [AW-1:0] wb_rd_i;
    logic [DW-1:0] wb_data_i;
    logic          clear_i;
    logic [AW-1:0] shadow_addr_i;
    logic [DW-1:0] shadow_data_o;
    logic [3:0]    count_o;
    logic          overflow_o;
    logic [SW-1:0] dropped_o;

    wb_trace_buffer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .SEQ_WIDTH(SW)) tif ();

    wb_trace_buffer #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH), .SEQ_WIDTH(SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_we_i      (wb_we_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .clear_i      (clear_i),
        .trace_if     (tif),
        .shadow_addr_i(shadow_addr_i),
        .shadow_data_o(shadow_data_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .dropped_o    (dropped_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rec_t          m_q[$];
    logic [DW-1:0] m_shadow[32];
    logic [SW-1:0] m_seq;
    logic          m_ov;
    logic [SW-1:0] m_drop;
    logic [SW-1:0] popped[$];

    bit            stall_prev;
    rec_t          stall_rec;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_shadow[i] = '0;
        m_seq      = '0;
        m_ov       = 1'b0;
        m_drop     = '0;
        stall_prev = 1'b0;
    endtask

    // Behaviour at one rising edge, from the documented rules.
    task automatic model_step(input bit we, input logic [AW-1:0] rd, input logic [DW-1:0] data,
                              input bit rdy, input bit clr);
        bit ev = we && (rd != 0);
        bit pop;
        if (ev) m_shadow[rd] = data;
        if (clr) begin
            m_q.delete();
            m_seq  = '0;
            m_ov   = 1'b0;
            m_drop = '0;
        end else begin
            pop = (m_q.size() > 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) m_q.push_back(rec_t'{rd: rd, data: data, seq: m_seq});
                else begin
                    m_ov = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 1'b1;
                end
                m_seq = m_seq + 1'b1;
            end
        end
    endtask

    task automatic check_state();
        chk("valid", tif.trace_valid, m_q.size() != 0);
        chk("count", count_o, m_q.size());
        chk("overflow", overflow_o, m_ov);
        chk("dropped", dropped_o, m_drop);
        chk("shadow", shadow_data_o, m_shadow[shadow_addr_i]);
        if (m_q.size() != 0) begin
            chk("head_rd", tif.trace_rd, m_q[0].rd);
            chk("head_data", tif.trace_data, m_q[0].data);
            chk("head_seq", tif.trace_seq, m_q[0].seq);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance one edge.
    task automatic cycle(input bit we, input logic [AW-1:0] rd, input logic [DW-1:0] data,
                         input bit rdy, input bit clr);
        wb_we_i         = we;
        wb_rd_i         = rd;
        wb_data_i       = data;
        tif.trace_ready = rdy;
        clear_i         = clr;
        shadow_addr_i   = AW'($urandom_range(0, 31));
        #1;
        check_state();
        if (stall_prev) begin
            chk("stall_rd", tif.trace_rd, stall_rec.rd);
            chk("stall_data", tif.trace_data, stall_rec.data);
            chk("stall_seq", tif.trace_seq, stall_rec.seq);
        end
        if (tif.trace_valid && rdy && !clr) popped.push_back(tif.trace_seq);
        stall_prev = tif.trace_valid && !rdy && !clr;
        stall_rec  = rec_t'{rd: tif.trace_rd, data: tif.trace_data, seq: tif.trace_seq};
        @(posedge clk);
        model_step(we, rd, data, rdy, clr);
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        shadow_addr_i = addr;
        #1;
        chk(tag, shadow_data_o, exp);
    endtask

    initial begin
        rst_n = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0; clear_i = 1'b0;
        tif.trace_ready = 1'b0; shadow_addr_i = 5'd7;
        model_reset();
        #2;
        chk("rst_valid", tif.trace_valid, 1'b0);
        chk("rst_count", count_o, 0);
        chk("rst_rd", tif.trace_rd, 0);
        chk("rst_data", tif.trace_data, 0);
        chk("rst_seq", tif.trace_seq, 0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_dropped", dropped_o, 0);
        chk("rst_shadow", shadow_data_o, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic
        cycle(1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 5'd2, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 5'd0, 32'h99, 1'b0, 1'b0);
        chk("basic_count", count_o, 2);
        chk("basic_head_rd", tif.trace_rd, 1);
        chk("basic_head_data", tif.trace_data, 32'h11);
        chk("basic_head_seq", tif.trace_seq, 0);
        peek("basic_shadow0", 5'd0, 32'h0);
        peek("basic_shadow2", 5'd2, 32'h22);
        idle(1'b1);
        chk("basic_pop_rd", tif.trace_rd, 2);
        chk("basic_pop_data", tif.trace_data, 32'h22);
        chk("basic_pop_seq", tif.trace_seq, 1);

        // Overflow
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'd5, DW'(i), 1'b0, 1'b0);
        chk("ovf_count", count_o, 8);
        chk("ovf_flag", overflow_o, 1'b1);
        chk("ovf_dropped", dropped_o, 2);
        peek("ovf_shadow5", 5'd5, 32'd9);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_seq", tif.trace_seq, i);
            idle(1'b1);
        end
        chk("ovf_empty", tif.trace_valid, 1'b0);

        // Full with simultaneous pop
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 5'd7, DW'(32'h100 + i), 1'b0, 1'b0);
        chk("fullpop_pre_count", count_o, 8);
        cycle(1'b1, 5'd7, 32'hF00D, 1'b1, 1'b0);
        chk("fullpop_count", count_o, 8);
        chk("fullpop_overflow", overflow_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("fullpop_seq", tif.trace_seq, i + 1);
            if (i == 7) chk("fullpop_new_data", tif.trace_data, 32'hF00D);
            idle(1'b1);
        end

        // Backpressure
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        popped.delete();
        cycle(1'b1, 5'd10, $urandom, 1'b1, 1'b0);
        cycle(1'b1, 5'd11, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 5'd12, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 5'd13, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("bp_popped_n", popped.size(), 4);
        for (int i = 0; i < popped.size(); i++) chk("bp_order", popped[i], i);

        // Clear
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'd4, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("clr_pre_count", count_o, 3);
        chk("clr_pre_ovf", overflow_o, 1'b1);
        cycle(1'b1, 5'd3, 32'hAB, 1'b0, 1'b1);
        chk("clr_count", count_o, 0);
        chk("clr_ovf", overflow_o, 1'b0);
        chk("clr_dropped", dropped_o, 0);
        peek("clr_shadow3", 5'd3, 32'hAB);
        cycle(1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
        chk("clr_next_valid", tif.trace_valid, 1'b1);
        chk("clr_next_seq", tif.trace_seq, 0);

        // Reset mid-burst
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle(1'b1, AW'(i), DW'(32'hC0 + i), 1'b0, 1'b0);
        chk("rmb_pre_count", count_o, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("rmb_valid", tif.trace_valid, 1'b0);
        chk("rmb_count", count_o, 0);
        peek("rmb_shadow1", 5'd1, 32'h0);
        peek("rmb_shadow2", 5'd2, 32'h0);
        peek("rmb_shadow3", 5'd3, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, AW'($urandom_range(0, 31)), $urandom,
                  (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
